// File: rtl/vga_window_compositor_pkg.sv
// Shared constants and types for the VGA window compositor.
package vga_window_compositor_pkg;

  localparam int P_WIDTH_DEF  = 11;
  localparam int D_WIDTH_DEF  = 4;
  localparam int NUM_WIN_DEF  = 4;
  localparam int BORDER_W_DEF = 2;
  localparam int H_ACT        = 640;
  localparam int V_ACT        = 480;

  // Config field selector carried on cfg_field
  typedef enum logic [2:0] {
    FLD_X0   = 3'd0,
    FLD_Y0   = 3'd1,
    FLD_X1   = 3'd2,
    FLD_Y1   = 3'd3,
    FLD_MODE = 3'd4,
    FLD_WCOL = 3'd5,
    FLD_BG   = 3'd6,
    FLD_NONE = 3'd7
  } cfg_field_e;

  // Per-window compositing mode
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_PASS   = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BORDER = 2'd3
  } win_mode_e;

  // Commit FSM: shadow->active copy waits for the next frame start
  typedef enum logic {
    CS_IDLE    = 1'b0,
    CS_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/vga_window_compositor_if.sv
// Configuration bus of the compositor. There is no ready: cfg_we and
// cfg_commit are single-cycle strobes that the compositor always accepts in
// the cycle they are high; cfg_pending/cfg_state report the commit FSM.
interface vga_window_compositor_if #(
  parameter int NUM_WIN = vga_window_compositor_pkg::NUM_WIN_DEF
) ();
  import vga_window_compositor_pkg::*;

  localparam int WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic             cfg_we;
  logic [WIN_W-1:0] cfg_win;
  logic [2:0]       cfg_field;
  logic [31:0]      cfg_data;
  logic             cfg_commit;
  logic             cfg_pending;
  commit_state_e    cfg_state;

  modport master (
    output cfg_we, cfg_win, cfg_field, cfg_data, cfg_commit,
    input  cfg_pending, cfg_state
  );

  modport slave (
    input  cfg_we, cfg_win, cfg_field, cfg_data, cfg_commit,
    output cfg_pending, cfg_state
  );

endinterface

// File: rtl/vga_win_hit.sv
// Combinational hit and border test of one pixel against one window.
module vga_win_hit
  import vga_window_compositor_pkg::*;
#(
  parameter int P_WIDTH  = P_WIDTH_DEF,
  parameter int BORDER_W = BORDER_W_DEF
) (
  input  logic [P_WIDTH-1:0] x_i,
  input  logic [P_WIDTH-1:0] y_i,
  input  logic [P_WIDTH-1:0] x0_i,
  input  logic [P_WIDTH-1:0] y0_i,
  input  logic [P_WIDTH-1:0] x1_i,
  input  logic [P_WIDTH-1:0] y1_i,
  output logic               hit_o,
  output logic               on_border_o
);

  localparam logic [P_WIDTH:0] BW = (P_WIDTH+1)'(BORDER_W);

  logic [P_WIDTH:0] xe, ye, x0e, y0e, x1e, y1e;

  // Half-open hit; right/bottom edges tested as X+BW>=x1 so nothing underflows
  always_comb begin
    xe  = {1'b0, x_i};
    ye  = {1'b0, y_i};
    x0e = {1'b0, x0_i};
    y0e = {1'b0, y0_i};
    x1e = {1'b0, x1_i};
    y1e = {1'b0, y1_i};
    hit_o = (x0_i <= x_i) && (x_i < x1_i) && (y0_i <= y_i) && (y_i < y1_i);
    on_border_o = (xe < x0e + BW) || (xe + BW >= x1e) ||
                  (ye < y0e + BW) || (ye + BW >= y1e);
  end

endmodule

// File: rtl/vga_window_compositor.sv
// Overlays NUM_WIN prioritised rectangular windows on the pixel stream.
// Config is double-buffered; shadow->active copy happens at frame start.
// Two-stage pipeline: S1 = hit/border test, S2 = priority mux.
module vga_window_compositor
  import vga_window_compositor_pkg::*;
#(
  parameter int P_WIDTH  = P_WIDTH_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int NUM_WIN  = NUM_WIN_DEF,
  parameter int BORDER_W = BORDER_W_DEF
) (
  input  logic               VGA_CLK,
  input  logic               RST_N,
  input  logic [P_WIDTH-1:0] X,
  input  logic [P_WIDTH-1:0] Y,
  input  logic               valid,
  input  logic [D_WIDTH-1:0] Red,
  input  logic [D_WIDTH-1:0] Green,
  input  logic [D_WIDTH-1:0] Blue,
  vga_window_compositor_if.slave cfg,
  output logic [D_WIDTH-1:0] VGA_R,
  output logic [D_WIDTH-1:0] VGA_G,
  output logic [D_WIDTH-1:0] VGA_B,
  output logic               out_valid
);

  localparam int C_W = 3 * D_WIDTH;

  typedef logic [P_WIDTH-1:0] coord_t;
  typedef logic [C_W-1:0]     col_t;

  // Shadow (written by cfg bus), active (used by pixels), effective (active,
  // or shadow on the applying frame-start cycle so that pixel sees the new set)
  coord_t    x0_sh_q [NUM_WIN], y0_sh_q [NUM_WIN], x1_sh_q [NUM_WIN], y1_sh_q [NUM_WIN];
  win_mode_e mode_sh_q [NUM_WIN];
  col_t      wcol_sh_q [NUM_WIN];
  col_t      bg_sh_q;
  coord_t    x0_ac_q [NUM_WIN], y0_ac_q [NUM_WIN], x1_ac_q [NUM_WIN], y1_ac_q [NUM_WIN];
  win_mode_e mode_ac_q [NUM_WIN];
  col_t      wcol_ac_q [NUM_WIN];
  col_t      bg_ac_q;
  coord_t    x0_ef [NUM_WIN], y0_ef [NUM_WIN], x1_ef [NUM_WIN], y1_ef [NUM_WIN];
  win_mode_e mode_ef [NUM_WIN];
  col_t      wcol_ef [NUM_WIN];
  col_t      bg_ef;

  commit_state_e state_q, state_d;
  cfg_field_e    fld;
  logic          frame_start, apply, cfg_wr;
  logic          unused_cfg_bits;

  logic [NUM_WIN-1:0] hit, on_border, qual_d, usecol_d, qual_q, usecol_q;
  col_t               wcol_s1_q [NUM_WIN];
  col_t               bg_s1_q, src_s1_q;
  logic               valid_s1_q;
  col_t               pix_d, pix_q;
  logic               out_valid_q;

  assign unused_cfg_bits = ^cfg.cfg_data[31:C_W];

  // Decode frame start, commit apply and legal config writes
  always_comb begin
    fld         = cfg_field_e'(cfg.cfg_field);
    frame_start = valid && (X == '0) && (Y == '0);
    apply       = frame_start && (state_q == CS_PENDING);
    cfg_wr      = cfg.cfg_we &&
                  ((fld == FLD_BG) ||
                   ((fld <= FLD_WCOL) && (32'(cfg.cfg_win) < 32'(NUM_WIN))));
  end

  // Shadow register writes from the config bus
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        x0_sh_q[w]   <= '0;
        y0_sh_q[w]   <= '0;
        x1_sh_q[w]   <= '0;
        y1_sh_q[w]   <= '0;
        mode_sh_q[w] <= MODE_OFF;
        wcol_sh_q[w] <= '0;
      end
      bg_sh_q <= '0;
    end else if (cfg_wr) begin
      case (fld)
        FLD_X0:   x0_sh_q[cfg.cfg_win]   <= cfg.cfg_data[P_WIDTH-1:0];
        FLD_Y0:   y0_sh_q[cfg.cfg_win]   <= cfg.cfg_data[P_WIDTH-1:0];
        FLD_X1:   x1_sh_q[cfg.cfg_win]   <= cfg.cfg_data[P_WIDTH-1:0];
        FLD_Y1:   y1_sh_q[cfg.cfg_win]   <= cfg.cfg_data[P_WIDTH-1:0];
        FLD_MODE: mode_sh_q[cfg.cfg_win] <= win_mode_e'(cfg.cfg_data[1:0]);
        FLD_WCOL: wcol_sh_q[cfg.cfg_win] <= cfg.cfg_data[C_W-1:0];
        FLD_BG:   bg_sh_q                <= cfg.cfg_data[C_W-1:0];
        default:  ;
      endcase
    end
  end

  // Active set copies the pre-write shadow values at an applying frame start
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        x0_ac_q[w]   <= '0;
        y0_ac_q[w]   <= '0;
        x1_ac_q[w]   <= '0;
        y1_ac_q[w]   <= '0;
        mode_ac_q[w] <= MODE_OFF;
        wcol_ac_q[w] <= '0;
      end
      bg_ac_q <= '0;
    end else if (apply) begin
      x0_ac_q   <= x0_sh_q;
      y0_ac_q   <= y0_sh_q;
      x1_ac_q   <= x1_sh_q;
      y1_ac_q   <= y1_sh_q;
      mode_ac_q <= mode_sh_q;
      wcol_ac_q <= wcol_sh_q;
      bg_ac_q   <= bg_sh_q;
    end
  end

  // Commit FSM state register
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= CS_IDLE;
    else        state_q <= state_d;
  end

  // Commit FSM next state: a commit arriving with the apply keeps it pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      CS_IDLE:    if (cfg.cfg_commit) state_d = CS_PENDING;
      CS_PENDING: if (apply && !cfg.cfg_commit) state_d = CS_IDLE;
      default:    state_d = CS_IDLE;
    endcase
  end

  // Commit FSM outputs
  always_comb begin
    cfg.cfg_pending = (state_q == CS_PENDING);
    cfg.cfg_state   = state_q;
  end

  // Effective config seen by the current pixel
  always_comb begin
    for (int w = 0; w < NUM_WIN; w++) begin
      x0_ef[w]   = apply ? x0_sh_q[w]   : x0_ac_q[w];
      y0_ef[w]   = apply ? y0_sh_q[w]   : y0_ac_q[w];
      x1_ef[w]   = apply ? x1_sh_q[w]   : x1_ac_q[w];
      y1_ef[w]   = apply ? y1_sh_q[w]   : y1_ac_q[w];
      mode_ef[w] = apply ? mode_sh_q[w] : mode_ac_q[w];
      wcol_ef[w] = apply ? wcol_sh_q[w] : wcol_ac_q[w];
    end
    bg_ef = apply ? bg_sh_q : bg_ac_q;
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_hit
    vga_win_hit #(
      .P_WIDTH  (P_WIDTH),
      .BORDER_W (BORDER_W)
    ) u_hit (
      .x_i         (X),
      .y_i         (Y),
      .x0_i        (x0_ef[g]),
      .y0_i        (y0_ef[g]),
      .x1_i        (x1_ef[g]),
      .y1_i        (y1_ef[g]),
      .hit_o       (hit[g]),
      .on_border_o (on_border[g])
    );
  end

  // S1 per-window select: qualified hit and "use window colour instead of source"
  always_comb begin
    for (int w = 0; w < NUM_WIN; w++) begin
      qual_d[w]   = hit[w] && (mode_ef[w] != MODE_OFF);
      usecol_d[w] = (mode_ef[w] == MODE_FILL) ||
                    ((mode_ef[w] == MODE_BORDER) && on_border[w]);
    end
  end

  // S1 registers: selects, colours and the delayed source pixel
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      qual_q     <= '0;
      usecol_q   <= '0;
      for (int w = 0; w < NUM_WIN; w++) wcol_s1_q[w] <= '0;
      bg_s1_q    <= '0;
      src_s1_q   <= '0;
      valid_s1_q <= 1'b0;
    end else begin
      qual_q     <= qual_d;
      usecol_q   <= usecol_d;
      wcol_s1_q  <= wcol_ef;
      bg_s1_q    <= bg_ef;
      src_s1_q   <= {Red, Green, Blue};
      valid_s1_q <= valid;
    end
  end

  // S2 priority mux: scan downwards so the lowest hitting index wins
  always_comb begin
    pix_d = bg_s1_q;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (qual_q[w]) pix_d = usecol_q[w] ? wcol_s1_q[w] : src_s1_q;
    end
    if (!valid_s1_q) pix_d = '0;
  end

  // S2 output registers
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      out_valid_q <= valid_s1_q;
    end
  end

  assign VGA_R     = pix_q[C_W-1 -: D_WIDTH];
  assign VGA_G     = pix_q[2*D_WIDTH-1 -: D_WIDTH];
  assign VGA_B     = pix_q[D_WIDTH-1:0];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vga_window_compositor.sv
// Bench for vga_window_compositor: directed tables, hand sequences for the
// commit corner cases and mid-frame reset, then random traffic vs a model.
module tb_vga_window_compositor;
  import vga_window_compositor_pkg::*;

  localparam int NW = 4;
  localparam int BW = 2;

  typedef struct {
    int         x;
    int         y;
    bit         v;
    logic [11:0] src;
    logic [11:0] exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [10:0] px_x, px_y;
  logic        px_valid;
  logic [3:0]  red, green, blue;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        out_valid;

  vga_window_compositor_if #(.NUM_WIN(NW)) cfg_bus ();

  vga_window_compositor dut (
    .VGA_CLK   (clk),
    .RST_N     (rst_n),
    .X         (px_x),
    .Y         (px_y),
    .valid     (px_valid),
    .Red       (red),
    .Green     (green),
    .Blue      (blue),
    .cfg       (cfg_bus),
    .VGA_R     (vga_r),
    .VGA_G     (vga_g),
    .VGA_B     (vga_b),
    .out_valid (out_valid)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: {out_valid, RGB} expected per driven pixel
  logic [12:0] exp_q[$];
  string       nm_q[$];

  // reference model of the programmed state
  int          sh_x0[NW], sh_y0[NW], sh_x1[NW], sh_y1[NW], sh_mode[NW];
  logic [11:0] sh_col[NW];
  logic [11:0] sh_bg;
  int          ac_x0[NW], ac_y0[NW], ac_x1[NW], ac_y1[NW], ac_mode[NW];
  logic [11:0] ac_col[NW];
  logic [11:0] ac_bg;
  bit          m_pend;

  // config action to present with the next pixel
  bit          we_b, com_b;
  int          win_b, fld_b;
  logic [31:0] dat_b;

  vec_t tab2a[2];
  vec_t tab2b[7];
  vec_t tab3[8];
  vec_t tab4[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) begin
      sh_x0[w] = 0; sh_y0[w] = 0; sh_x1[w] = 0; sh_y1[w] = 0; sh_mode[w] = 0; sh_col[w] = '0;
      ac_x0[w] = 0; ac_y0[w] = 0; ac_x1[w] = 0; ac_y1[w] = 0; ac_mode[w] = 0; ac_col[w] = '0;
    end
    sh_bg  = '0;
    ac_bg  = '0;
    m_pend = 1'b0;
  endtask

  function automatic logic [11:0] model_px(int x, int y, bit v, logic [11:0] src);
    if (!v) return 12'h000;
    for (int w = 0; w < NW; w++) begin
      if (ac_mode[w] != 0 && x >= ac_x0[w] && x < ac_x1[w] && y >= ac_y0[w] && y < ac_y1[w]) begin
        if (ac_mode[w] == 1) return src;
        if (ac_mode[w] == 2) return ac_col[w];
        if (x < ac_x0[w] + BW || x >= ac_x1[w] - BW || y < ac_y0[w] + BW || y >= ac_y1[w] - BW)
          return ac_col[w];
        return src;
      end
    end
    return ac_bg;
  endfunction

  task automatic model_write(int win, int fld, logic [31:0] d);
    case (fld)
      0: sh_x0[win]   = int'(d & 32'h7FF);
      1: sh_y0[win]   = int'(d & 32'h7FF);
      2: sh_x1[win]   = int'(d & 32'h7FF);
      3: sh_y1[win]   = int'(d & 32'h7FF);
      4: sh_mode[win] = int'(d & 32'h3);
      5: sh_col[win]  = d[11:0];
      6: sh_bg        = d[11:0];
      default: ;
    endcase
  endtask

  // driver: one pixel cycle (plus any queued config action), then check
  task automatic step(int x, int y, bit v, logic [11:0] src, bit use_tab,
                      logic [11:0] tab_exp, string name);
    logic [12:0] got;
    bit fs;
    px_x = 11'(x);
    px_y = 11'(y);
    px_valid = v;
    {red, green, blue} = src;
    cfg_bus.cfg_we     = we_b;
    cfg_bus.cfg_win    = 2'(win_b);
    cfg_bus.cfg_field  = 3'(fld_b);
    cfg_bus.cfg_data   = dat_b;
    cfg_bus.cfg_commit = com_b;
    fs = v && (x == 0) && (y == 0);
    if (fs && m_pend) begin
      ac_x0 = sh_x0; ac_y0 = sh_y0; ac_x1 = sh_x1; ac_y1 = sh_y1;
      ac_mode = sh_mode; ac_col = sh_col; ac_bg = sh_bg;
      m_pend = com_b;
    end else if (com_b) begin
      m_pend = 1'b1;
    end
    exp_q.push_back({v, use_tab ? tab_exp : model_px(x, y, v, src)});
    nm_q.push_back(name);
    if (we_b) model_write(win_b, fld_b, dat_b);
    we_b = 1'b0;
    com_b = 1'b0;
    @(posedge clk);
    #1;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    if (exp_q.size() > 1) begin
      got = {out_valid, vga_r, vga_g, vga_b};
      chk(nm_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    end
    chk({name, "_pend"}, 32'(cfg_bus.cfg_pending), 32'(m_pend));
  endtask

  task automatic cfg_wr(int win, int fld, logic [31:0] d);
    we_b = 1'b1; win_b = win; fld_b = fld; dat_b = d;
    step(0, 1, 1'b0, 12'h000, 1'b0, 12'h000, "cfg");
  endtask

  task automatic commit();
    com_b = 1'b1;
    step(0, 1, 1'b0, 12'h000, 1'b0, 12'h000, "commit");
  endtask

  task automatic frame_start();
    step(0, 0, 1'b1, 12'h123, 1'b0, 12'h000, "fstart");
  endtask

  task automatic prog_win(int w, int x0, int y0, int x1, int y1, int mode, logic [11:0] col);
    cfg_wr(w, 0, 32'(x0));
    cfg_wr(w, 1, 32'(y0));
    cfg_wr(w, 2, 32'(x1));
    cfg_wr(w, 3, 32'(y1));
    cfg_wr(w, 4, 32'(mode));
    cfg_wr(w, 5, {20'h0, col});
  endtask

  task automatic run_tab(vec_t t, string nm);
    step(t.x, t.y, t.v, t.src, 1'b1, t.exp, nm);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rgb"},    32'({vga_r, vga_g, vga_b}), 32'h0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'h0);
    chk({tag, "_pend"},   32'(cfg_bus.cfg_pending), 32'h0);
  endtask

  task automatic after_release();
    model_clear();
    exp_q.delete();
    nm_q.delete();
    exp_q.push_back(13'h0);
    nm_q.push_back("post_rst");
  endtask

  task automatic mid_reset();
    px_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    after_release();
  endtask

  initial begin
    int x, y;
    bit v;
    logic [31:0] d;

    tab2a = '{'{100, 100, 1'b1, 12'hABC, 12'h000}, '{300, 200, 1'b1, 12'hABC, 12'h000}};
    tab2b = '{'{100, 100, 1'b1, 12'hABC, 12'hABC}, '{ 99, 100, 1'b1, 12'hABC, 12'h000},
              '{540, 100, 1'b1, 12'hABC, 12'h000}, '{539, 379, 1'b1, 12'h5A5, 12'h5A5},
              '{539, 380, 1'b1, 12'hABC, 12'h000}, '{300,  99, 1'b1, 12'hABC, 12'h000},
              '{300, 200, 1'b0, 12'hABC, 12'h000}};
    tab3  = '{'{260, 260, 1'b1, 12'hABC, 12'hF00}, '{299, 299, 1'b1, 12'hABC, 12'hF00},
              '{300, 300, 1'b1, 12'hABC, 12'hABC}, '{350, 350, 1'b1, 12'h0C3, 12'h0C3},
              '{250, 210, 1'b1, 12'hABC, 12'hF00}, '{399, 399, 1'b1, 12'hABC, 12'hABC},
              '{400, 400, 1'b1, 12'hABC, 12'h000}, '{199, 260, 1'b1, 12'hABC, 12'h000}};
    tab4  = '{'{11, 15, 1'b1, 12'hABC, 12'h0F0}, '{12, 15, 1'b1, 12'hABC, 12'hABC},
              '{18, 15, 1'b1, 12'hABC, 12'h0F0}, '{17, 15, 1'b1, 12'hABC, 12'hABC},
              '{15, 10, 1'b1, 12'hABC, 12'h0F0}, '{15, 11, 1'b1, 12'hABC, 12'h0F0},
              '{15, 12, 1'b1, 12'hABC, 12'hABC}, '{15, 17, 1'b1, 12'hABC, 12'hABC},
              '{15, 18, 1'b1, 12'hABC, 12'h0F0}, '{19, 19, 1'b1, 12'hABC, 12'h0F0},
              '{20, 15, 1'b1, 12'hABC, 12'h00A}, '{ 9, 15, 1'b1, 12'hABC, 12'h00A},
              '{ 5,  5, 1'b0, 12'hABC, 12'h000}, '{260, 260, 1'b1, 12'hABC, 12'hF00}};

    we_b = 1'b0; com_b = 1'b0; win_b = 0; fld_b = 0; dat_b = '0;
    px_x = '0; px_y = '0; px_valid = 1'b0; red = '0; green = '0; blue = '0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_win = '0; cfg_bus.cfg_field = '0;
    cfg_bus.cfg_data = '0; cfg_bus.cfg_commit = 1'b0;
    rst_n = 1'b1;
    model_clear();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    after_release();

    // 1: scaled frame with blanking, everything off -> all zero
    for (int yy = 0; yy < 48; yy++)
      for (int xx = 0; xx < 80; xx++)
        step(xx, yy, xx < 64, 12'($urandom), 1'b0, 12'h000, "t1_off");

    // 2: pass window, committed mid-frame, applies at the next frame
    frame_start();
    prog_win(0, 100, 100, 540, 380, 1, 12'h000);
    commit();
    for (int i = 0; i < 2; i++) run_tab(tab2a[i], $sformatf("t2_frame1_%0d", i));
    frame_start();
    for (int i = 0; i < 7; i++) run_tab(tab2b[i], $sformatf("t2_frame2_%0d", i));

    // 3: overlapping fill (index 0) and pass (index 1)
    prog_win(0, 200, 200, 300, 300, 2, 12'hF00);
    prog_win(1, 250, 250, 400, 400, 1, 12'h000);
    commit();
    frame_start();
    for (int i = 0; i < 8; i++) run_tab(tab3[i], $sformatf("t3_prio_%0d", i));

    // 4: border window plus a background colour; frame-start pixel sees new bg
    prog_win(1, 10, 10, 20, 20, 3, 12'h0F0);
    cfg_wr(0, 6, 32'h00A);
    commit();
    step(0, 0, 1'b1, 12'h123, 1'b1, 12'h00A, "t4_fs_newbg");
    for (int i = 0; i < 14; i++) run_tab(tab4[i], $sformatf("t4_border_%0d", i));

    // 5: write on the applying frame-start cycle lands in shadow only
    cfg_wr(1, 2, 32'd30);
    commit();
    we_b = 1'b1; win_b = 1; fld_b = 2; dat_b = 32'd40;
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_fs_we");
    step(25, 15, 1'b1, 12'hABC, 1'b1, 12'hABC, "t5_x1_30_in");
    step(29, 15, 1'b1, 12'hABC, 1'b1, 12'h0F0, "t5_x1_30_edge");
    step(35, 15, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_x1_30_out");
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_fs_nocommit");
    step(35, 15, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_still_30");
    commit();
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_fs_apply40");
    step(35, 15, 1'b1, 12'hABC, 1'b1, 12'hABC, "t5_x1_40_in");
    step(39, 15, 1'b1, 12'hABC, 1'b1, 12'h0F0, "t5_x1_40_edge");
    step(29, 15, 1'b1, 12'hABC, 1'b1, 12'hABC, "t5_x1_40_mid");
    // commit on the applying cycle keeps the request pending
    commit();
    com_b = 1'b1;
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_fs_commit");
    cfg_wr(1, 2, 32'd20);
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_fs_reapply");
    step(25, 15, 1'b1, 12'hABC, 1'b1, 12'h00A, "t5_x1_20");

    // 6: reset mid-line while the fill window drives non-zero output
    for (int i = 0; i < 3; i++) step(250 + i, 210, 1'b1, 12'hABC, 1'b1, 12'hF00, "t6_pre");
    mid_reset();
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h000, "t6_post_fs");
    for (int i = 0; i < 6; i++) step(250 + i, 210, 1'b1, 12'hABC, 1'b1, 12'h000, "t6_post");
    prog_win(0, 200, 200, 300, 300, 2, 12'hF00);
    commit();
    step(0, 0, 1'b1, 12'hABC, 1'b1, 12'h000, "t6_fs");
    step(250, 210, 1'b1, 12'hABC, 1'b1, 12'hF00, "t6_reprog");

    // 7: random windows, config traffic and pixels against the model
    for (int w = 0; w < NW; w++)
      prog_win(w, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(10, 63),
               $urandom_range(10, 63), $urandom_range(0, 3), 12'($urandom));
    cfg_wr(0, 6, $urandom);
    commit();
    frame_start();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        we_b = 1'b1;
        win_b = $urandom_range(0, NW - 1);
        fld_b = $urandom_range(0, 7);
        d = $urandom;
        dat_b = (fld_b < 4) ? ((d & 32'hFFFF_F800) | 32'($urandom_range(0, 63))) : d;
      end
      if ($urandom_range(0, 99) < 2) com_b = 1'b1;
      if ($urandom_range(0, 149) == 0) begin
        x = 0; y = 0; v = 1'b1;
      end else begin
        x = $urandom_range(0, 63);
        y = $urandom_range(0, 63);
        v = ($urandom_range(0, 3) != 0);
      end
      step(x, y, v, 12'($urandom), 1'b0, 12'h000, "t7_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
